// File: rtl/matrix_loader_4x4.sv
// rtl/matrix_loader_4x4.sv - streams 16 signed elements into a packed 4x4 matrix with ack handshake
// Optional MATRIX_LOADER_COL_MAJOR_EN: write element k to row k%4, column k/4 instead of row-major.
module matrix_loader_4x4 #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic signed [ELEM_W-1:0]          elem_in,
  input  logic                              elem_valid,
  output logic                              elem_ready,
  output logic signed [DIM*DIM*ELEM_W-1:0]  matriz_4x4,
  output logic                              matrix_valid,
  input  logic                              matrix_ack,
  output logic [4:0]                        elem_count
);

  localparam int N  = DIM * DIM;
  localparam int AW = $clog2(N * ELEM_W);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic [3:0]    slot;
  logic [AW-1:0] base;

  assign accept = elem_valid && elem_ready && !clear;

  // Element k lands in matrix slot k, or its transpose position in the column-major build.
  always_comb begin
`ifdef MATRIX_LOADER_COL_MAJOR_EN
    slot = {elem_count[1:0], elem_count[3:2]};
`else
    slot = elem_count[3:0];
`endif
    base = AW'((N - 1 - int'(slot)) * ELEM_W);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = FILL;
        FILL:    if (accept && elem_count == 5'd15) state_nxt = FULL;
        FULL:    if (matrix_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    elem_ready   = (state != FULL);
    matrix_valid = (state == FULL);
  end

  // Matrix contents survive ack; only clear and reset wipe them.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      elem_count <= 5'd0;
      matriz_4x4 <= '0;
    end else if (state == FULL) begin
      if (matrix_ack) elem_count <= 5'd0;
    end else if (accept) begin
      elem_count                  <= elem_count + 5'd1;
      matriz_4x4[base +: ELEM_W]  <= elem_in;
    end
  end

endmodule

// File: tb/tb_matrix_loader_4x4.sv
// tb/tb_matrix_loader_4x4.sv - randomized self-checking bench for matrix_loader_4x4 against an array model
module tb_matrix_loader_4x4;

  logic         clk = 1'b0;
  logic         rst, clear, elem_valid, matrix_ack;
  logic [7:0]   elem_in;
  logic         elem_ready, matrix_valid;
  logic [127:0] matriz_4x4;
  logic [4:0]   elem_count;

  matrix_loader_4x4 #(.ELEM_W(8), .DIM(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .elem_in(elem_in),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .matriz_4x4(matriz_4x4),
    .matrix_valid(matrix_valid), .matrix_ack(matrix_ack), .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  bit         checking = 0;
  int         m_count;
  bit         m_full;
  logic [7:0] m_mat[16];

`ifdef MATRIX_LOADER_COL_MAJOR_EN
  localparam logic [127:0] SEQ_MATRIX = 128'h0105090D02060A0E03070B0F04080C10;
`else
  localparam logic [127:0] SEQ_MATRIX = 128'h0102030405060708090A0B0C0D0E0F10;
`endif

  function automatic int slot_of(input int k);
`ifdef MATRIX_LOADER_COL_MAJOR_EN
    return 4 * (k % 4) + k / 4;
`else
    return k;
`endif
  endfunction

  function automatic logic [127:0] model_packed();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = m_mat[i];
    return v;
  endfunction

  function automatic int det4(input logic [127:0] p);
    int a[4][4];
    int cols[3];
    int n, minor, d;
    logic [7:0] b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        b = p[127-8*(4*r+c) -: 8];
        a[r][c] = int'($signed(b));
      end
    d = 0;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      for (int k = 0; k < 4; k++) if (k != j) begin cols[n] = k; n++; end
      minor = a[1][cols[0]] * (a[2][cols[1]] * a[3][cols[2]] - a[2][cols[2]] * a[3][cols[1]])
            - a[1][cols[1]] * (a[2][cols[0]] * a[3][cols[2]] - a[2][cols[2]] * a[3][cols[0]])
            + a[1][cols[2]] * (a[2][cols[0]] * a[3][cols[1]] - a[2][cols[1]] * a[3][cols[0]]);
      d += ((j % 2) ? -1 : 1) * a[0][j] * minor;
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances with the same inputs the DUT samples on this edge.
  task automatic model_step();
    if (rst || clear) begin
      m_count = 0;
      m_full  = 0;
      for (int i = 0; i < 16; i++) m_mat[i] = 8'h00;
    end else if (m_full) begin
      if (matrix_ack) begin
        m_full  = 0;
        m_count = 0;
      end
    end else if (elem_valid) begin
      m_mat[slot_of(m_count)] = elem_in;
      m_count++;
      if (m_count == 16) m_full = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("elem_ready", 128'(elem_ready), 128'(!m_full));
      chk("matrix_valid", 128'(matrix_valid), 128'(m_full));
      chk("elem_count", 128'(elem_count), 128'(m_count));
      chk("matriz_4x4", matriz_4x4, model_packed());
    end
  end

  task automatic idle_inputs();
    elem_valid = 0; matrix_ack = 0; clear = 0; rst = 0; elem_in = 8'h00;
  endtask

  task automatic send(input logic [7:0] v);
    elem_valid = 1; elem_in = v;
    tick();
    elem_valid = 0;
  endtask

  task automatic ack_once();
    matrix_ack = 1;
    tick();
    matrix_ack = 0;
  endtask

  initial begin
    logic [7:0] diag[16];
    idle_inputs();
    rst = 1;
    tick();
    checking = 1;
    tick();
    rst = 0;
    chk("reset_count", 128'(elem_count), 128'd0);
    chk("reset_ready", 128'(elem_ready), 128'd1);
    chk("reset_matrix", matriz_4x4, 128'd0);

    // Back-to-back 1..16
    for (int k = 0; k < 16; k++) begin
      elem_valid = 1; elem_in = 8'(k + 1);
      tick();
      if (k == 14) chk("valid_before_last", 128'(matrix_valid), 128'd0);
    end
    chk("seq_valid", 128'(matrix_valid), 128'd1);
    chk("seq_ready", 128'(elem_ready), 128'd0);
    chk("seq_matrix", matriz_4x4, SEQ_MATRIX);

    // Backpressure while full
    elem_valid = 1; elem_in = 8'h55;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_matrix", matriz_4x4, SEQ_MATRIX);
    chk("bp_count", 128'(elem_count), 128'd16);
    matrix_ack = 1;
    tick();
    idle_inputs();
    chk("ack_count", 128'(elem_count), 128'd0);
    chk("ack_valid", 128'(matrix_valid), 128'd0);
    chk("ack_ready", 128'(elem_ready), 128'd1);
    chk("ack_keeps_matrix", matriz_4x4, SEQ_MATRIX);

    // Diagonal matrix, determinant -24
    for (int i = 0; i < 16; i++) diag[i] = 8'h00;
    diag[0] = 8'd2; diag[5] = 8'd3; diag[10] = 8'd4; diag[15] = 8'hFF;
    for (int i = 0; i < 16; i++) send(diag[i]);
    chk_int("determinant", det4(matriz_4x4), -24);
    ack_once();

    // Abort after 7 elements
    for (int i = 0; i < 7; i++) send(8'($urandom));
    clear = 1; elem_valid = 1; elem_in = 8'hA5;
    tick();
    idle_inputs();
    chk("clear_count", 128'(elem_count), 128'd0);
    chk("clear_matrix", matriz_4x4, 128'd0);
    for (int i = 0; i < 16; i++) send(8'($urandom));
    chk("reload_valid", 128'(matrix_valid), 128'd1);
    ack_once();

    // Random gaps, stray acks, occasional clear/reset
    for (int i = 0; i < 1500; i++) begin
      elem_valid = ($urandom_range(0, 1) == 1);
      elem_in    = 8'($urandom);
      matrix_ack = ($urandom_range(0, 4) == 0);
      clear      = ($urandom_range(0, 99) < 2);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_loader_4x4.md
MATRIX_LOADER_4X4 -- requirements
Module: matrix_loader_4x4

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 8, giving the signed element width in bits.
REQ-002 The block SHALL have parameter DIM, default 4, giving the matrix dimension; only 4 is supported.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port clear, input, 1 bit: synchronous abort of the matrix being loaded.
REQ-006 Port elem_in, input, ELEM_W bits, signed: the incoming matrix element.
REQ-007 Port elem_valid, input, 1 bit: elem_in is valid this cycle.
REQ-008 Port elem_ready, output, 1 bit: the block can accept an element this cycle.
REQ-009 Port matriz_4x4, output, DIM*DIM*ELEM_W (128) bits, signed: the packed matrix presented to the determinant block.
REQ-010 Port matrix_valid, output, 1 bit: matriz_4x4 holds a complete matrix.
REQ-011 Port matrix_ack, input, 1 bit: the consumer has taken the matrix.
REQ-012 Port elem_count, output, 5 bits: the number of elements accepted into the current matrix (0..16).

Function
REQ-013 The state machine SHALL have three states: IDLE (count 0), FILL (count 1..15) and FULL (count 16).
REQ-014 elem_ready SHALL be 1 in IDLE and FILL, and 0 in FULL.
REQ-015 An element SHALL be accepted only on a cycle with elem_valid=1 and elem_ready=1; each accept increments elem_count by 1.
REQ-016 The k-th accepted element (k=0..15) SHALL be written to matriz_4x4 bits [127-8k : 120-8k]: row-major order, element 0 at the most significant byte.
REQ-017 Transitions: IDLE to FILL on the first accept; FILL to FULL on the 16th accept; FULL to IDLE on matrix_ack=1.
REQ-018 Latency: matrix_valid SHALL assert on the cycle after the 16th accept and stay high until acknowledged.
REQ-019 On matrix_ack in FULL, the block SHALL go to IDLE the next cycle with matrix_valid=0, elem_count=0 and elem_ready=1.
REQ-020 matriz_4x4 SHALL keep its contents after ack; each byte is overwritten only when its new element is accepted.
REQ-021 matrix_ack in IDLE or FILL SHALL be ignored.
REQ-022 If elem_valid and matrix_ack are both 1 in FULL, the ack SHALL be taken and the element SHALL NOT be accepted, because elem_ready=0.
REQ-023 clear=1 SHALL, on the next cycle, force IDLE, elem_count=0, matrix_valid=0 and matriz_4x4=0, from any state; an element presented on that cycle SHALL be dropped.
REQ-024 Priority SHALL be rst > clear > matrix_ack > element accept.
REQ-025 Elements SHALL be stored bit-exact, with no sign extension or arithmetic applied.

Reset
REQ-026 With rst=1 at a rising edge, the next state SHALL be: IDLE, elem_count=0, matrix_valid=0, matriz_4x4=0, elem_ready=1.
REQ-027 A reset in the middle of a load SHALL discard all partial data, with the same result as REQ-026.

Configuration
REQ-028 With macro MATRIX_LOADER_COL_MAJOR_EN defined, the k-th element SHALL go to row k%4, column k/4, i.e. bits [127-8(4(k%4)+k/4) : 120-8(4(k%4)+k/4)]; without the macro, the order SHALL be row-major as in REQ-016.
REQ-029 The macro SHALL affect only write addressing; all handshake timing SHALL be identical in both builds.

Verification
REQ-030 Row-major load: after reset, send elements 1,2,...,16 back-to-back -> matrix_valid=1 one cycle after the last accept; matriz_4x4 = 128'h0102030405060708090A0B0C0D0E0F10; elem_ready=0.
REQ-031 Determinant check: load 2,0,0,0, 0,3,0,0, 0,0,4,0, 0,0,0,-1 (8'hFF) and feed the result to the determinant block -> det = -24.
REQ-032 Backpressure: in FULL, hold elem_valid=1 with elem_in=8'h55 for 5 cycles, then ack -> matriz_4x4 unchanged, elem_count stays 16, IDLE the next cycle.
REQ-033 Abort: accept 7 elements, assert clear for one cycle -> elem_count=0, matriz_4x4=0; then load 16 new elements -> correct matrix with no leftovers.
REQ-034 Gaps and stray ack: insert random idle cycles between elem_valid pulses and pulse matrix_ack during FILL -> load unaffected, matrix_valid only after the 16th accept.
REQ-035 Column-major build (macro defined): send 1..16 -> matriz_4x4 = 128'h0105090D02060A0E03070B0F04080C10.
